// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and framebuffer geometry for the framebuffer port arbiter
// Contents: grant and FSM state enums, framebuffer dimensions used by the
// arbiter and by the TIA pixel address computation.
package fb_arb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous FIFO buffering TIA pixel writes
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, wdata_i     push request and entry; ignored when full unless popping
//   pop_i               pop request; ignored when empty
//   rdata_o             head entry (valid while !empty_o)
//   full_o, empty_o     status flags
//   level_o             occupancy, one bit wider than the pointers
module fb_wr_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level == LVL_W'(DEPTH));
  assign empty_o = (level == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = mem[rd_ptr];
  assign level_o = level;

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single-port framebuffer RAM arbiter: scanout reads, buffered TIA writes, frame clear
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   wr_valid_i, wr_addr_i, wr_data_i     TIA pixel write strobe/address/colour
//   rd_req_i, rd_addr_i, rd_ack_o        scanout read request handshake
//   rd_valid_o, rd_data_o                scanout read return (one-cycle pulse)
//   clr_i, clr_data_i, busy_o            frame clear start, colour, in-progress flag
//   wr_overflow_o, wr_clip_o             sticky dropped-write / out-of-range flags
//   ram_en_o, ram_we_o, ram_addr_o,
//   ram_wdata_o, ram_rdata_i             registered single-port RAM interface
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int FB_SIZE     = FB_PIXELS,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] clr_data_i,
  output logic                  busy_o,
  output logic                  wr_overflow_o,
  output logic                  wr_clip_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] FB_LIMIT  = ADDR_WIDTH'(FB_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);

  state_e                  state_q;
  state_e                  state_d;
  grant_e                  grant;
  logic                    contention;
  logic                    favour_write_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic [DATA_WIDTH-1:0]   clr_color_q;
  logic                    wr_in_range;
  logic                    wr_src_avail;
  logic                    clear_done;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ENTRY_W-1:0]      fifo_head;
  logic [LVL_W-1:0]        fifo_level;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [RAM_LATENCY:0]    rd_pipe_q;

  assign wr_in_range = (wr_addr_i < FB_LIMIT);
  assign fifo_push   = wr_valid_i && wr_in_range;
  // The FIFO is frozen during a clear; the clear counter is the write source.
  assign fifo_pop    = (grant == GNT_WRITE) && (state_q == ST_IDLE);
  assign {head_addr, head_data} = fifo_head;
  assign wr_src_avail = (state_q == ST_CLEAR) || !fifo_empty;

  fb_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({wr_addr_i, wr_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Reads win unless the FIFO is full; then reads and writes take turns so
  // scanout cannot starve the writer and vice versa.
  always_comb begin
    grant      = GNT_NONE;
    contention = 1'b0;
    if (rst_i) begin
      grant = GNT_NONE;
    end else if (rd_req_i && !fifo_full) begin
      grant = GNT_READ;
    end else if (rd_req_i) begin
      contention = 1'b1;
      grant      = favour_write_q ? GNT_WRITE : GNT_READ;
    end else if (wr_src_avail) begin
      grant = GNT_WRITE;
    end
  end

  assign rd_ack_o   = (grant == GNT_READ);
  assign clear_done = (state_q == ST_CLEAR) && (grant == GNT_WRITE) && (clr_cnt_q == LAST_ADDR);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; a new clr_i during a clear restarts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_i) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (clr_i)           state_d = ST_CLEAR;
        else if (clear_done) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == ST_CLEAR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      favour_write_q <= 1'b1;
      clr_cnt_q      <= '0;
      clr_color_q    <= '0;
      wr_overflow_o  <= 1'b0;
      wr_clip_o      <= 1'b0;
      ram_en_o       <= 1'b0;
      ram_we_o       <= 1'b0;
      ram_addr_o     <= '0;
      ram_wdata_o    <= '0;
      rd_pipe_q      <= '0;
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
    end else begin
      if (contention) favour_write_q <= !favour_write_q;

      if (clr_i) begin
        clr_cnt_q   <= '0;
        clr_color_q <= clr_data_i;
      end else if ((state_q == ST_CLEAR) && (grant == GNT_WRITE)) begin
        clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
      end

      if (fifo_push && (fifo_level == LVL_W'(FIFO_DEPTH)) && !fifo_pop) wr_overflow_o <= 1'b1;
      if (wr_valid_i && !wr_in_range) wr_clip_o <= 1'b1;

      ram_en_o <= (grant != GNT_NONE);
      ram_we_o <= (grant == GNT_WRITE);
      case (grant)
        GNT_READ: begin
          ram_addr_o  <= rd_addr_i;
          ram_wdata_o <= '0;
        end
        GNT_WRITE: begin
          if (state_q == ST_CLEAR) begin
            ram_addr_o  <= clr_cnt_q;
            ram_wdata_o <= clr_color_q;
          end else begin
            ram_addr_o  <= head_addr;
            ram_wdata_o <= head_data;
          end
        end
        default: begin
          ram_addr_o  <= '0;
          ram_wdata_o <= '0;
        end
      endcase

      // Bit k marks a read whose RAM access was issued k cycles ago; the top
      // bit lines up with the cycle where ram_rdata_i is valid.
      rd_pipe_q  <= (rd_pipe_q << 1) | (RAM_LATENCY + 1)'(grant == GNT_READ);
      rd_valid_o <= rd_pipe_q[RAM_LATENCY];
      if (rd_pipe_q[RAM_LATENCY]) rd_data_o <= ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - self-checking bench for fb_port_arbiter against a queue-based reference model
module tb_fb_port_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 7;
  localparam int DEPTH = 4;
  localparam int FBS   = 38400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_valid, rd_req, clr;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, clr_data;
  logic          rd_ack, rd_valid, busy, ovf, clip, ram_en, ram_we;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  fb_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FB_SIZE(FBS), .RAM_LATENCY(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .clr_i(clr), .clr_data_i(clr_data), .busy_o(busy),
    .wr_overflow_o(ovf), .wr_clip_o(clip),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Environment RAM, one cycle read latency.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // Reference model state
  typedef struct { int addr; int data; } wr_t;
  typedef struct { int due;  int data; } rd_t;
  wr_t  q[$];
  rd_t  rdq[$];
  int   shadow [0:65535];
  bit   clearing, ovf_m, clip_m;
  int   clr_cnt, clr_color;
  int   last_win;     // 1: read won last full-contention cycle, 2: write won
  int   m_grant;      // 0 none, 1 read, 2 write
  bit   e_en, e_we;
  int   e_addr, e_wdata;
  int   n;
  int   checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_step();
    wr_t w;
    if (rst) begin
      q.delete(); rdq.delete();
      clearing = 0; clr_cnt = 0; clr_color = 0; ovf_m = 0; clip_m = 0;
      last_win = 1; m_grant = 0; e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      return;
    end
    if (rd_req && q.size() < DEPTH) m_grant = 1;
    else if (rd_req) begin
      m_grant  = (last_win == 1) ? 2 : 1;
      last_win = m_grant;
    end
    else if (clearing || q.size() > 0) m_grant = 2;
    else m_grant = 0;
    e_en = (m_grant != 0);
    e_we = (m_grant == 2);
    if (m_grant == 1) begin
      e_addr = rd_addr;
      rdq.push_back('{n + 2, shadow[rd_addr]});
    end else if (m_grant == 2) begin
      if (clearing) begin
        e_addr = clr_cnt; e_wdata = clr_color;
        if (clr_cnt == FBS - 1) clearing = 0;
        else clr_cnt++;
      end else begin
        w = q.pop_front();
        e_addr = w.addr; e_wdata = w.data;
      end
      shadow[e_addr] = e_wdata;
    end
    if (wr_valid) begin
      if (int'(wr_addr) >= FBS)  clip_m = 1;
      else if (q.size() < DEPTH) q.push_back('{int'(wr_addr), int'(wr_data)});
      else                       ovf_m = 1;
    end
    if (clr) begin
      clearing = 1; clr_cnt = 0; clr_color = clr_data;
    end
  endtask

  task automatic post_check();
    bit exp_v;
    check("ram_en", ram_en, e_en);
    check("ram_we", ram_we, e_we);
    if (e_en) check("ram_addr", ram_addr, e_addr);
    if (e_we) check("ram_wdata", ram_wdata, e_wdata);
    exp_v = (rdq.size() > 0) && (rdq[0].due == n);
    check("rd_valid", rd_valid, exp_v);
    if (exp_v) begin
      check("rd_data", rd_data, rdq[0].data);
      void'(rdq.pop_front());
    end
    check("busy", busy, clearing);
    check("wr_overflow", ovf, ovf_m);
    check("wr_clip", clip, clip_m);
  endtask

  // Inputs are set at the falling edge; the model sees them 1 ns later,
  // registered outputs are checked 1 ns after the rising edge.
  task automatic tick();
    #1;
    model_step();
    check("rd_ack", rd_ack, (m_grant == 1));
    @(posedge clk);
    #1;
    post_check();
    n++;
    @(negedge clk);
  endtask

  task automatic put_write(input int a, input int d);
    wr_valid = 1; wr_addr = AW'(a); wr_data = DW'(d);
  endtask

  int cw;

  initial begin
    checks = 0; errors = 0; n = 0;
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; shadow[i] = 0; end
    ram_rdata = '0;
    rst = 1; wr_valid = 0; rd_req = 0; clr = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; clr_data = '0;
    @(negedge clk);
    tick(); tick();
    check("reset_ram_en", ram_en, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_valid", rd_valid, 0);
    rst = 0;

    // Idle write
    put_write(16'h0123, 7'h55); tick(); wr_valid = 0;
    tick();
    check("idle_wr_en", ram_en, 1);
    check("idle_wr_we", ram_we, 1);
    check("idle_wr_addr", ram_addr, 16'h0123);
    check("idle_wr_data", ram_wdata, 7'h55);
    tick();
    check("idle_fifo_empty", ram_en, 0);

    // Seed 0x200, then read priority over two buffered writes
    put_write(16'h0200, 7'h2A); tick(); wr_valid = 0; tick();
    rd_req = 1; rd_addr = 16'h0210; put_write(16'h0300, 1); tick();
    rd_req = 1; rd_addr = 16'h0210; put_write(16'h0301, 2); tick();
    wr_valid = 0; rd_req = 1; rd_addr = 16'h0200;
    #1 check("rdprio_ack", rd_ack, 1);
    tick(); rd_req = 0;
    check("rdprio_we", ram_we, 0);
    tick();
    check("rdprio_w1_addr", ram_addr, 16'h0300);
    tick();
    check("rdprio_w2_addr", ram_addr, 16'h0301);
    check("rdprio_valid", rd_valid, 1);
    check("rdprio_data", rd_data, 7'h2A);

    // Overflow: continuous reads while six writes arrive back to back
    for (int i = 0; i < 6; i++) begin
      rd_req = 1; rd_addr = AW'(16'h0400 + i);
      put_write(16'h0500 + i, 7'h40 + i);
      tick();
    end
    wr_valid = 0; rd_req = 0;
    for (int i = 0; i < 8; i++) tick();
    check("overflow_sticky", ovf, 1);

    // Clip boundary
    put_write(FBS, 7'h11); tick(); wr_valid = 0; tick();
    check("clip_sticky", clip, 1);
    check("clip_no_write", ram_en, 0);
    put_write(FBS - 1, 7'h7F); tick(); wr_valid = 0; tick();
    check("last_addr_we", ram_we, 1);
    check("last_addr", ram_addr, FBS - 1);

    // Frame clear with a TIA write arriving mid-clear
    clr = 1; clr_data = 7'h10; tick(); clr = 0;
    cw = 0;
    for (int i = 0; i < 40000 && clearing; i++) begin
      if (i == 100) put_write(5, 7'h33);
      tick();
      wr_valid = 0;
      if (ram_we && ram_wdata == 7'h10) cw++;
    end
    check("clear_write_count", cw, FBS);
    check("clear_busy_low", busy, 0);
    tick();
    check("post_clear_tia_addr", ram_addr, 5);
    check("post_clear_tia_data", ram_wdata, 7'h33);

    // Reset during a clear with two reads in flight
    clr = 1; clr_data = 7'h22; tick(); clr = 0;
    for (int i = 0; i < 50; i++) tick();
    rd_req = 1; rd_addr = 16'h0040; tick();
    rd_req = 1; rd_addr = 16'h0041; tick();
    rd_req = 0; rst = 1; tick(); rst = 0;
    check("rst_busy", busy, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_overflow", ovf, 0);
    check("rst_clip", clip, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_rd_valid", rd_valid, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = ($urandom_range(0, 31) == 0) ? AW'($urandom_range(FBS, 65535))
                                              : AW'($urandom_range(0, 1023));
      wr_data  = DW'($urandom);
      if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req  = 1;
        rd_addr = AW'($urandom_range(0, 1023));
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
      if (m_grant == 1) rd_req = 0;
      rst = 0;
    end
    wr_valid = 0; rd_req = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
